// File: rtl/mips_pkg.sv
// Shared MIPS load/store definitions: aluop encodings, byte enables, LSU FSM states
// and the decode helpers used by the MEM stage.
package mips_pkg;

    localparam logic [4:0] LW  = 5'h10;
    localparam logic [4:0] LH  = 5'h11;
    localparam logic [4:0] LHU = 5'h12;
    localparam logic [4:0] LB  = 5'h13;
    localparam logic [4:0] LBU = 5'h14;
    localparam logic [4:0] SW  = 5'h15;
    localparam logic [4:0] SH  = 5'h16;
    localparam logic [4:0] SB  = 5'h17;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic logic is_mem_aluop(input logic [4:0] op);
        case (op)
            LW, LH, LHU, LB, LBU, SW, SH, SB: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic lsu_size_e access_size(input logic [4:0] op);
        case (op)
            LB, LBU, SB: return SZ_BYTE;
            LH, LHU, SH: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load data formatter: picks the byte/half lane addressed by the low address bits
// and sign- or zero-extends it according to the load opcode.
module lsu_load_format
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [4:0]  aluop,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = rdata;
        case (byte_off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (byte_off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (aluop)
            LB:      data = {{24{byte_s[7]}}, byte_s};
            LBU:     data = {24'h000000, byte_s};
            LH:      data = {{16{half_s[15]}}, half_s};
            LHU:     data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one req/ack data-memory access per memory op,
// stalls the pipeline while it is outstanding and registers the MEM/WB bundle.
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_aluresult,
    input  logic [31:0] MEM_swdata,
    input  logic [4:0]  MEM_writeaddr,
    input  logic        MEM_memread,
    input  logic        MEM_memwrite,
    input  logic        MEM_regwrite,
    input  logic        MEM_memtoreg,
    input  logic [4:0]  MEM_aluop,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] WB_result,
    output logic [4:0]  WB_writeaddr,
    output logic        WB_regwrite,
    output logic        WB_memtoreg,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_r;
    logic [7:0]  tmo_cnt_r;
    logic [31:0] rdata_cap_r;
    logic        wb_ok_r;
    logic        is_load_r;
    logic [1:0]  byte_off_r;
    logic [4:0]  aluop_r;

    logic        mem_op_s;
    logic        store_s;
    logic        misaligned_s;
    lsu_size_e   size_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] load_data_s;

    // Decode the incoming op and build the store lanes / byte enables
    always_comb begin
        mem_op_s     = (MEM_memread | MEM_memwrite) & is_mem_aluop(MEM_aluop);
        store_s      = MEM_memwrite;
        size_s       = access_size(MEM_aluop);
        misaligned_s = 1'b0;
        be_s         = BE_ALL;
        wdata_s      = 32'h0000_0000;
        if (mem_op_s) begin
            case (size_s)
                SZ_HALF: misaligned_s = MEM_aluresult[0];
                SZ_WORD: misaligned_s = (MEM_aluresult[1:0] != 2'b00);
                default: misaligned_s = 1'b0;
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
        if (store_s) begin
            case (size_s)
                SZ_BYTE: begin
                    wdata_s = {4{MEM_swdata[7:0]}};
                    be_s    = BE_BYTE0 << MEM_aluresult[1:0];
                end
                SZ_HALF: begin
                    wdata_s = {2{MEM_swdata[15:0]}};
                    be_s    = MEM_aluresult[1] ? BE_HI_HALF : BE_LO_HALF;
                end
                default: begin
                    wdata_s = MEM_swdata;
                    be_s    = BE_ALL;
                end
            endcase
        end else begin
            wdata_s = 32'h0000_0000;
            be_s    = BE_ALL;
        end
    end

    // Stall is held low during reset so the frozen stages never see a stray freeze
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            mem_stall = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: mem_stall = mem_op_s & ~misaligned_s;
                ST_REQ:  mem_stall = 1'b1;
                ST_DONE: mem_stall = 1'b0;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    lsu_load_format u_load_format (
        .rdata    (dmem_rdata),
        .byte_off (byte_off_r),
        .aluop    (aluop_r),
        .data     (load_data_s)
    );

    // Access FSM with registered request, error pulses and MEM/WB bundle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            tmo_cnt_r    <= 8'd0;
            rdata_cap_r  <= 32'h0000_0000;
            wb_ok_r      <= 1'b0;
            is_load_r    <= 1'b0;
            byte_off_r   <= 2'b00;
            aluop_r      <= 5'h00;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0000_0000;
            dmem_wdata   <= 32'h0000_0000;
            dmem_be      <= BE_NONE;
            WB_result    <= 32'h0000_0000;
            WB_writeaddr <= 5'd0;
            WB_regwrite  <= 1'b0;
            WB_memtoreg  <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s && !misaligned_s) begin
                        state_r    <= ST_REQ;
                        tmo_cnt_r  <= 8'd0;
                        is_load_r  <= ~store_s;
                        byte_off_r <= MEM_aluresult[1:0];
                        aluop_r    <= MEM_aluop;
                        dmem_req   <= 1'b1;
                        dmem_we    <= store_s;
                        dmem_addr  <= {MEM_aluresult[31:2], 2'b00};
                        dmem_wdata <= wdata_s;
                        dmem_be    <= be_s;
                    end else begin
                        WB_result    <= MEM_aluresult;
                        WB_writeaddr <= MEM_writeaddr;
                        WB_regwrite  <= MEM_regwrite & ~misaligned_s;
                        WB_memtoreg  <= MEM_memtoreg;
                        misalign_err <= misaligned_s;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        rdata_cap_r <= load_data_s;
                        wb_ok_r     <= 1'b1;
                        state_r     <= ST_DONE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        dmem_be     <= BE_NONE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rdata_cap_r <= 32'h0000_0000;
                        wb_ok_r     <= 1'b0;
                        timeout_err <= 1'b1;
                        state_r     <= ST_DONE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        dmem_be     <= BE_NONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    WB_result    <= is_load_r ? rdata_cap_r : MEM_aluresult;
                    WB_writeaddr <= MEM_writeaddr;
                    WB_regwrite  <= MEM_regwrite & wb_ok_r;
                    WB_memtoreg  <= MEM_memtoreg;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expectations, TIMEOUT_CYCLES=4.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] MEM_aluresult = 32'h0;
    logic [31:0] MEM_swdata = 32'h0;
    logic [4:0]  MEM_writeaddr = 5'd0;
    logic        MEM_memread = 1'b0;
    logic        MEM_memwrite = 1'b0;
    logic        MEM_regwrite = 1'b0;
    logic        MEM_memtoreg = 1'b0;
    logic [4:0]  MEM_aluop = 5'h00;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic        mem_stall;
    logic [31:0] WB_result;
    logic [4:0]  WB_writeaddr;
    logic        WB_regwrite;
    logic        WB_memtoreg;
    logic        misalign_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_aluresult(MEM_aluresult), .MEM_swdata(MEM_swdata),
        .MEM_writeaddr(MEM_writeaddr), .MEM_memread(MEM_memread),
        .MEM_memwrite(MEM_memwrite), .MEM_regwrite(MEM_regwrite),
        .MEM_memtoreg(MEM_memtoreg), .MEM_aluop(MEM_aluop),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .mem_stall(mem_stall),
        .WB_result(WB_result), .WB_writeaddr(WB_writeaddr),
        .WB_regwrite(WB_regwrite), .WB_memtoreg(WB_memtoreg),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sw,
                          input logic [4:0] wa, input logic rd, input logic wr,
                          input logic rw, input logic m2r);
        MEM_aluop = op; MEM_aluresult = addr; MEM_swdata = sw; MEM_writeaddr = wa;
        MEM_memread = rd; MEM_memwrite = wr; MEM_regwrite = rw; MEM_memtoreg = m2r;
        #1;
    endtask

    task automatic set_nop();
        set_op(5'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_nop();
        step(); step();
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== 70'h0) begin
            errors++; $display("FAIL reset_dmem actual=%h expected=0", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be});
        end
        checks++;
        if ({WB_result, WB_writeaddr, WB_regwrite, WB_memtoreg, misalign_err, timeout_err, mem_stall} !== 43'h0) begin
            errors++; $display("FAIL reset_wb actual=%h expected=0", {WB_result, WB_writeaddr, WB_regwrite, WB_memtoreg, misalign_err, timeout_err, mem_stall});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_nonmem();
        set_op(5'h02, 32'h0000_00AA, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("nonmem_stall", {31'h0, mem_stall}, 32'h0);
        step();
        chk("nonmem_result", WB_result, 32'h0000_00AA);
        chk("nonmem_waddr", {27'h0, WB_writeaddr}, 32'd3);
        chk("nonmem_regwrite", {31'h0, WB_regwrite}, 32'd1);
        chk("nonmem_req", {31'h0, dmem_req}, 32'd0);
        set_nop();
    endtask

    task automatic test_lb();
        int stall_cycles = 0;
        set_op(5'h13, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        if (mem_stall) stall_cycles++;
        step();
        chk("lb_req", {31'h0, dmem_req}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h0000_0100);
        chk("lb_be", {28'h0, dmem_be}, 32'hF);
        chk("lb_we", {31'h0, dmem_we}, 32'd0);
        if (mem_stall) stall_cycles++;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h80AB_CDEF;
        if (mem_stall) stall_cycles++;
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        if (mem_stall) stall_cycles++;
        chk("lb_req_drop", {31'h0, dmem_req}, 32'd0);
        chk("lb_stall_cycles", stall_cycles, 32'd3);
        chk("lb_wb_before_done", WB_result, 32'h0000_00AA);
        step();
        set_nop();
        chk("lb_result", WB_result, 32'hFFFF_FF80);
        chk("lb_regwrite", {31'h0, WB_regwrite}, 32'd1);
        chk("lb_waddr", {27'h0, WB_writeaddr}, 32'd5);
        step();
    endtask

    task automatic test_store(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sw,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be, input string nm);
        set_op(op, addr, sw, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk({nm, "_stall"}, {31'h0, mem_stall}, 32'd1);
        step();
        chk({nm, "_we"}, {31'h0, dmem_we}, 32'd1);
        chk({nm, "_be"}, {28'h0, dmem_be}, {28'h0, exp_be});
        chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
        chk({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk({nm, "_done_stall"}, {31'h0, mem_stall}, 32'd0);
        step();
        set_nop();
        chk({nm, "_regwrite"}, {31'h0, WB_regwrite}, 32'd0);
        chk({nm, "_result"}, WB_result, addr);
        step();
    endtask

    task automatic test_misalign();
        set_op(5'h10, 32'h0000_0006, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mis_stall", {31'h0, mem_stall}, 32'd0);
        step();
        set_nop();
        chk("mis_err", {31'h0, misalign_err}, 32'd1);
        chk("mis_req", {31'h0, dmem_req}, 32'd0);
        chk("mis_regwrite", {31'h0, WB_regwrite}, 32'd0);
        step();
        chk("mis_err_pulse", {31'h0, misalign_err}, 32'd0);
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        set_op(5'h12, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            step();
        end
        chk("tmo_req_cycles", req_cycles, 32'd4);
        chk("tmo_err", {31'h0, timeout_err}, 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        step();
        dmem_ack = 1'b0;
        set_nop();
        chk("tmo_regwrite", {31'h0, WB_regwrite}, 32'd0);
        chk("tmo_waddr", {27'h0, WB_writeaddr}, 32'd9);
        chk("tmo_err_pulse", {31'h0, timeout_err}, 32'd0);
        chk("tmo_late_ack_req", {31'h0, dmem_req}, 32'd0);
        step();
    endtask

    task automatic test_reset_mid_req();
        set_op(5'h10, 32'h0000_0080, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk("rreq_req", {31'h0, dmem_req}, 32'd1);
        rst = 1'b0;
        step();
        chk("rreq_req_clr", {31'h0, dmem_req}, 32'd0);
        chk("rreq_addr_clr", dmem_addr, 32'h0);
        chk("rreq_be_clr", {28'h0, dmem_be}, 32'h0);
        chk("rreq_wb_clr", {WB_result[31:0]}, 32'h0);
        chk("rreq_stall", {31'h0, mem_stall}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("rreq_restart_stall", {31'h0, mem_stall}, 32'd1);
        step();
        chk("rreq_restart_req", {31'h0, dmem_req}, 32'd1);
        chk("rreq_restart_addr", dmem_addr, 32'h0000_0080);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        step();
        set_nop();
        chk("rreq_result", WB_result, 32'hDEAD_BEEF);
        chk("rreq_regwrite", {31'h0, WB_regwrite}, 32'd1);
        step();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lb();
        test_store(5'h16, 32'h0000_0022, 32'h1234_5678, 32'h5678_5678, 4'b1100, "sh");
        test_store(5'h17, 32'h0000_0001, 32'h0000_00AB, 32'hABAB_ABAB, 4'b0010, "sb");
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit. It consumes the MEM_* control and data bundle produced by the EX/MEM pipeline register and performs the data-memory access over a req/ack handshake. It holds the pipeline with mem_stall while an access is outstanding. It formats load data and registers the MEM/WB bundle for the writeback stage.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles REQ waits for dmem_ack before the access is aborted (range 1..255).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (asserted when 0)
MEM_aluresult  input  32  effective address, or ALU result for non-memory ops
MEM_swdata  input  32  store data (rt)
MEM_writeaddr  input  5  destination register
MEM_memread  input  1  load instruction
MEM_memwrite  input  1  store instruction
MEM_regwrite  input  1  register write enable
MEM_memtoreg  input  1  select load data for writeback
MEM_aluop  input  5  operation code; selects load/store width and extension
dmem_req  output  1  access request, held until ack
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_rdata  input  32  read word, valid with ack
dmem_ack  input  1  one-cycle completion pulse
mem_stall  output  1  combinational; freeze IF..EX/MEM while 1
WB_result  output  32  formatted load data or passthrough ALU result
WB_writeaddr  output  5  destination register
WB_regwrite  output  1  register write enable
WB_memtoreg  output  1  writeback source select
misalign_err  output  1  one-cycle pulse on a misaligned access
timeout_err  output  1  one-cycle pulse on an aborted access

Behaviour:
- Memory op: (MEM_memread|MEM_memwrite) with aluop in {LW,LH,LHU,LB,LBU,SW,SH,SB}. memread and memwrite both high: treated as a store.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, REQ, DONE.
- IDLE, memory op, aligned: mem_stall=1; next state REQ with dmem_req/we/addr/wdata/be registered. Timeout counter cleared.
- IDLE, misaligned: no request; mem_stall=0; misalign_err pulses on the next edge; WB bundle loads with WB_regwrite=0.
- IDLE, non-memory op: mem_stall=0; WB bundle loads on the edge: WB_result=MEM_aluresult plus the control fields.
- REQ: mem_stall=1; request outputs held stable.
  - dmem_ack=1: capture formatted rdata, drop dmem_req, go to DONE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: drop req, pulse timeout_err, go to DONE with the regwrite capture forced 0.
  - dmem_ack is ignored in IDLE and DONE.
- DONE: mem_stall=0. WB bundle loads captured data (load) or the passthrough (store; WB_regwrite=MEM_regwrite, normally 0). Next state IDLE.
- The WB bundle updates only on edges where mem_stall=0. Latency: non-memory op 1 cycle. Memory op 2 cycles plus ack wait; ack in the first REQ cycle gives a total of 3 edges.
- Store formatting (little-endian):
  - SB: wdata={4{b}}, be=1<<addr[1:0].
  - SH: wdata={2{h}}, be=addr[1]?4'b1100:4'b0011.
  - SW: be=4'b1111.
  - Loads: be=4'b1111, wdata=0.
- Load formatting: select the byte/half lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend to 32 bits.
- Reset (rst==0 at an edge), including mid-REQ: state IDLE; dmem_req/we=0; dmem_addr/wdata=0; be=0; all WB_* and error outputs 0. The request is abandoned and a late ack is ignored.

Decomposition:
- Shared package (mips_pkg): aluop load/store constants LW=5'h10, LH=5'h11, LHU=5'h12, LB=5'h13, LBU=5'h14, SW=5'h15, SH=5'h16, SB=5'h17; FSM state enum; byte-enable constants.
- One natural sub-module: lsu_load_format, a combinational lane select plus sign/zero extend of (rdata, addr[1:0], aluop).

Test Plan:
- Non-memory op, aluresult=0x0000_00AA, writeaddr=3, regwrite=1 -> mem_stall stays 0; next edge WB_result=0xAA, WB_writeaddr=3, WB_regwrite=1.
- LB addr=0x103, ack 2 cycles after req, rdata=0x80AB_CDEF -> dmem_addr=0x100, be=4'b1111; mem_stall high 3 cycles; WB_result=0xFFFF_FF80.
- SH addr=0x22, swdata=0x1234_5678, ack immediate -> dmem_we=1, be=4'b1100, wdata=0x5678_5678; no regwrite.
- LW addr=0x06 -> no dmem_req; misalign_err pulses once; WB_regwrite=0; mem_stall never asserts.
- LHU addr=0x40, ack withheld, TIMEOUT_CYCLES=4 -> dmem_req high exactly 4 cycles; timeout_err pulses; WB_regwrite=0; late ack ignored.
- rst=0 during REQ -> next edge dmem_req=0, state IDLE, all outputs 0; rst=1 with the same instruction -> access restarts cleanly.
